// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised video timing generator. It divides the system
//                clock down to a pixel-enable strobe and keeps col/row
//                counters. It produces registered hsync/vsync/visible and
//                line/frame start strobes, with an optional extra output delay.
//                Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds the
//                16-bit frame_cnt output).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int C_PXL_VISIBLE  = 640,
  parameter int C_PXL_FPORCH   = 16,
  parameter int C_PXL_SYNCH    = 96,
  parameter int C_PXL_TOTAL    = 800,
  parameter int C_LINE_VISIBLE = 480,
  parameter int C_LINE_FPORCH  = 9,
  parameter int C_LINE_SYNCH   = 2,
  parameter int C_LINE_TOTAL   = 520,
  parameter int C_NB_PXLS      = 10,
  parameter int C_NB_LINES     = 10,
  parameter int C_CLK_DIV      = 2,
  parameter int C_HSYNC_ACT    = 0,
  parameter int C_VSYNC_ACT    = 0,
  parameter int C_PIPE_DLY     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  new_pxl,
  output logic [C_NB_PXLS-1:0]  col,
  output logic [C_NB_LINES-1:0] row,
  output logic                  visible,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  line_start,
  output logic                  frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int C_DIV_W = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(C_CLK_DIV - 1);

  localparam logic [C_NB_PXLS-1:0] C_COL_LAST = C_NB_PXLS'(C_PXL_TOTAL - 1);
  localparam logic [C_NB_PXLS-1:0] C_HVIS     = C_NB_PXLS'(C_PXL_VISIBLE);
  localparam logic [C_NB_PXLS-1:0] C_HS_BEG   = C_NB_PXLS'(C_PXL_VISIBLE + C_PXL_FPORCH);
  localparam logic [C_NB_PXLS-1:0] C_HS_END   = C_NB_PXLS'(C_PXL_VISIBLE + C_PXL_FPORCH + C_PXL_SYNCH);

  localparam logic [C_NB_LINES-1:0] C_ROW_LAST = C_NB_LINES'(C_LINE_TOTAL - 1);
  localparam logic [C_NB_LINES-1:0] C_VVIS     = C_NB_LINES'(C_LINE_VISIBLE);
  localparam logic [C_NB_LINES-1:0] C_VS_BEG   = C_NB_LINES'(C_LINE_VISIBLE + C_LINE_FPORCH);
  localparam logic [C_NB_LINES-1:0] C_VS_END   = C_NB_LINES'(C_LINE_VISIBLE + C_LINE_FPORCH + C_LINE_SYNCH);

  localparam logic C_HS_ON = C_HSYNC_ACT[0];
  localparam logic C_VS_ON = C_VSYNC_ACT[0];

  // Decoded output bundle: {visible, hsync, vsync, line_start, frame_start}
  localparam logic [4:0] C_IDLE = {1'b0, ~C_HS_ON, ~C_VS_ON, 2'b00};

  // Parameter sanity checks, reported at elaboration time
  if (C_CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: C_CLK_DIV must be >= 1");
  end
  if (C_PXL_TOTAL < C_PXL_VISIBLE + C_PXL_FPORCH + C_PXL_SYNCH + 1) begin : g_chk_htot
    $error("vga_timing_gen: C_PXL_TOTAL too small");
  end
  if (C_LINE_TOTAL < C_LINE_VISIBLE + C_LINE_FPORCH + C_LINE_SYNCH + 1) begin : g_chk_vtot
    $error("vga_timing_gen: C_LINE_TOTAL too small");
  end
  if ((2 ** C_NB_PXLS) < C_PXL_TOTAL) begin : g_chk_hw
    $error("vga_timing_gen: C_NB_PXLS too narrow");
  end
  if ((2 ** C_NB_LINES) < C_LINE_TOTAL) begin : g_chk_vw
    $error("vga_timing_gen: C_NB_LINES too narrow");
  end
  if (C_PIPE_DLY < 0 || C_PIPE_DLY > 15) begin : g_chk_pipe
    $error("vga_timing_gen: C_PIPE_DLY must be 0..15");
  end

  logic [C_DIV_W-1:0]    cnt_div_q, cnt_div_d;
  logic [C_NB_PXLS-1:0]  col_q, col_d;
  logic [C_NB_LINES-1:0] row_q, row_d;
  logic [4:0]            dec_q, dec_d;
  logic [4:0]            w_out;
  logic                  w_new_pxl;
  logic                  w_line_cond;
  logic                  w_frame_cond;
  logic                  w_hact, w_vact, w_hs_on, w_vs_on;

  assign w_new_pxl    = (cnt_div_q == C_DIV_LAST);
  assign w_line_cond  = w_new_pxl & (col_q == '0);
  assign w_frame_cond = w_line_cond & (row_q == '0);

  // Next-state for divider and raster counters, plus sync/visible decode
  always_comb begin
    cnt_div_d = (cnt_div_q == C_DIV_LAST) ? '0 : cnt_div_q + 1'b1;
    col_d     = col_q;
    row_d     = row_q;
    if (w_new_pxl) begin
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    w_hact  = (col_q < C_HVIS);
    w_vact  = (row_q < C_VVIS);
    w_hs_on = (col_q >= C_HS_BEG) && (col_q < C_HS_END);
    w_vs_on = (row_q >= C_VS_BEG) && (row_q < C_VS_END);
    dec_d   = {w_hact & w_vact,
               (w_hs_on ? C_HS_ON : ~C_HS_ON),
               (w_vs_on ? C_VS_ON : ~C_VS_ON),
               w_line_cond,
               w_frame_cond};
  end

  // Counter and decode registers; reset returns to (0,0) with idle outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_div_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      dec_q     <= C_IDLE;
    end else begin
      cnt_div_q <= cnt_div_d;
      col_q     <= col_d;
      row_q     <= row_d;
      dec_q     <= dec_d;
    end
  end

  // Optional alignment delay; shifts every clk so latency is in clk, not pixels
  if (C_PIPE_DLY == 0) begin : g_nodly
    assign w_out = dec_q;
  end else begin : g_dly
    logic [4:0] pipe_q [C_PIPE_DLY];

    // Shift register flushed to idle values on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < C_PIPE_DLY; i++) pipe_q[i] <= C_IDLE;
      end else begin
        pipe_q[0] <= dec_q;
        for (int i = 1; i < C_PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign w_out = pipe_q[C_PIPE_DLY-1];
  end

  assign new_pxl     = w_new_pxl;
  assign col         = col_q;
  assign row         = row_q;
  assign visible     = w_out[4];
  assign hsync       = w_out[3];
  assign vsync       = w_out[2];
  assign line_start  = w_out[1];
  assign frame_start = w_out[0];

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts frames on the undelayed frame-start condition, wrapping at 16 bits
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, w_frame_cond};
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  // No frame counter in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen using a small raster.
//                Expected values come from an arithmetic model indexed by the
//                number of clk edges since the last reset edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int DIV  = 3;
  localparam int HV   = 8;
  localparam int HF   = 2;
  localparam int HS   = 3;
  localparam int HT   = 16;
  localparam int VV   = 5;
  localparam int VF   = 1;
  localparam int VS   = 2;
  localparam int VT   = 10;
  localparam int PIPE = 2;
  localparam bit HACT = 1'b0;
  localparam bit VACT = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_pxl;
  logic [4:0] col;
  logic [3:0] row;
  logic       visible, hsync, vsync, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [15:0] exp_fc;
`endif

  int     tests = 0;
  int     fails = 0;
  longint k = 0;

  vga_timing_gen #(
    .C_PXL_VISIBLE (HV),
    .C_PXL_FPORCH  (HF),
    .C_PXL_SYNCH   (HS),
    .C_PXL_TOTAL   (HT),
    .C_LINE_VISIBLE(VV),
    .C_LINE_FPORCH (VF),
    .C_LINE_SYNCH  (VS),
    .C_LINE_TOTAL  (VT),
    .C_NB_PXLS     (5),
    .C_NB_LINES    (4),
    .C_CLK_DIV     (DIV),
    .C_HSYNC_ACT   (0),
    .C_VSYNC_ACT   (1),
    .C_PIPE_DLY    (PIPE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .new_pxl    (new_pxl),
    .col        (col),
    .row        (row),
    .visible    (visible),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Raster position after j edges since reset: pixel index = floor(j/DIV)
  function automatic void pos(input longint j, output int c, output int r, output bit np);
    longint p;
    p  = j / DIV;
    np = (j % DIV) == DIV - 1;
    c  = int'(p % HT);
    r  = int'((p / HT) % VT);
  endfunction

  // Expected {visible,hsync,vsync,line_start,frame_start} decoded at position j
  function automatic logic [4:0] exp_dec(input longint j);
    int c, r;
    bit np, vis, hs, vs, ls, fs;
    if (j < 0) return {1'b0, !HACT, !VACT, 2'b00};
    pos(j, c, r, np);
    vis = (c < HV) && (r < VV);
    hs  = (c >= HV + HF && c < HV + HF + HS) ? HACT : !HACT;
    vs  = (r >= VV + VF && r < VV + VF + VS) ? VACT : !VACT;
    ls  = np && (c == 0);
    fs  = ls && (r == 0);
    return {vis, hs, vs, ls, fs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    int c, r;
    bit np;
    logic [4:0] d;
    pos(k, c, r, np);
    d = exp_dec(k - 1 - PIPE);
    chk("col",         {27'd0, col},        c);
    chk("row",         {28'd0, row},        r);
    chk("new_pxl",     {31'd0, new_pxl},    {31'd0, np});
    chk("visible",     {31'd0, visible},    {31'd0, d[4]});
    chk("hsync",       {31'd0, hsync},      {31'd0, d[3]});
    chk("vsync",       {31'd0, vsync},      {31'd0, d[2]});
    chk("line_start",  {31'd0, line_start}, {31'd0, d[1]});
    chk("frame_start", {31'd0, frame_start},{31'd0, d[0]});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt",   {16'd0, frame_cnt},  {16'd0, exp_fc});
`endif
  endtask

  // One clk with the given reset level, then check just after the edge
  task automatic step(input bit r);
    int c, rr;
    bit np;
    pos(k, c, rr, np);
    rst = r;
    @(posedge clk);
    #1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (r) exp_fc = '0;
    else if (np && c == 0 && rr == 0) exp_fc = exp_fc + 16'd1;
`endif
    if (r) k = 0;
    else   k = k + 1;
    if (!r || k == 0) check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    // Reset held a few cycles: counters at zero, outputs idle
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Just over two full frames from reset
    run(2 * DIV * HT * VT + 37);

    // Randomised run lengths with reset pulses of random width
    for (int seg = 0; seg < 8; seg++) begin
      run(int'($urandom_range(40, 700)));
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) step(1'b1);
    end

    // Single-cycle reset mid-frame, then a full frame plus margin
    run(DIV * HT * 6 + 5 * DIV);
    step(1'b1);
    run(DIV * HT * VT + 20);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Preload the frame counter at its maximum; next frame start wraps it
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    exp_fc = 16'hFFFF;
    run(DIV * HT * VT + 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
